// File: rtl/mc_controller_if.sv
// mc_controller_if: the shared memory port between the multi-cycle control
// FSM and the memory system.
//   mem_req    - request, held high until mem_ready
//   mem_we     - 1 = store, 0 = read
//   mem_ifetch - address mux select: 1 = PC, 0 = ALU result
//   mem_ready  - completes the outstanding request
// master: the controller side; slave: the memory side.
interface mc_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_ifetch;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_ifetch, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_ifetch, output mem_ready);
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RISC-V control FSM. It sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over one shared memory port and one
// ALU, and retires one instruction per pass.
// Ports:
//   clk, reset_n             - clock, synchronous active-low reset
//   bus (master)             - mem_req / mem_we / mem_ifetch out, mem_ready in
//   opcode, funct3           - IR fields, sampled in DECODE only
//   branch_taken             - ALU compare result, used in EXEC
//   ir_write, pc_write,
//   pc_src, reg_write,
//   wb_sel, alu_src_b, alu_op - datapath strobes and mux selects
//   illegal, bus_err         - sticky error flags
//   halted                   - high in TRAP
//   instret                  - retired instruction count (wraps)
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mc_controller_if.master       bus,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  branch_taken,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  illegal,
  output logic                  bus_err,
  output logic                  halted,
  output logic [31:0]           instret
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL
  } class_e;

  // Last counter value before the request is declared lost.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  class_e      class_q, class_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;
  logic        retire;
  logic [3:0]  dec;

  // Returns {supported, class}.
  function automatic logic [3:0] decode_class(input logic [6:0] opc, input logic [2:0] f3);
    logic [3:0] r;
    r = {1'b0, C_R};
    unique case (opc)
      7'b0110011: r = {1'b1, C_R};
      7'b0010011: r = {1'b1, C_I};
      7'b0000011: if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) r = {1'b1, C_LOAD};
      7'b0100011: if (f3 inside {3'b000, 3'b001, 3'b010}) r = {1'b1, C_STORE};
      7'b1100011: if (!(f3 inside {3'b010, 3'b011})) r = {1'b1, C_BR};
      7'b1101111: r = {1'b1, C_JAL};
      default:    r = {1'b0, C_R};
    endcase
    return r;
  endfunction

  assign dec = decode_class(opcode, funct3);

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    tmo_d     = tmo_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        tmo_d   = 8'd0;
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec[3]) begin
          class_d = class_e'(dec[2:0]);
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        unique case (class_q)
          C_R, C_I:        state_d = S_WB;
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            tmo_d   = 8'd0;
          end
          default: begin  // BR, JAL retire here
            retire  = 1'b1;
            state_d = S_FETCH;
            tmo_d   = 8'd0;
          end
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (class_q == C_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
            tmo_d   = 8'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
        tmo_d   = 8'd0;
      end
      default: state_d = S_TRAP;  // TRAP is only left through reset
    endcase
    instret_d = instret_q + {31'd0, retire};
  end

  always_ff @(posedge clk) begin
    class_q <= class_d;
    if (!reset_n) begin
      state_q   <= S_BOOT;
      tmo_q     <= 8'd0;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Moore strobes from the registered state and class; ir_write, the
  // memory-completion pc_write and the branch pc_src also look at the
  // live mem_ready / branch_taken inputs.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_ifetch = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 2'b00;
    reg_write      = 1'b0;
    wb_sel         = 2'b00;
    alu_src_b      = 2'b00;
    alu_op         = 2'b00;
    halted         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.mem_ifetch = 1'b1;
        ir_write       = bus.mem_ready;
      end
      S_EXEC: begin
        unique case (class_q)
          C_R: alu_op = 2'b10;
          C_I: begin
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
          end
          C_LOAD, C_STORE: alu_src_b = 2'b01;
          C_BR: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
          end
          default: begin  // JAL
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            pc_write  = 1'b1;
            pc_src    = 2'b10;
          end
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (class_q == C_STORE);
        alu_src_b   = 2'b01;
        pc_write    = bus.mem_ready && (class_q == C_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (class_q == C_LOAD) ? 2'b01 : 2'b00;
        pc_write  = 1'b1;
      end
      S_TRAP:  halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller (MEM_TIMEOUT = 4).
// Each task drives one scenario cycle by cycle, pushes the expected strobe
// vector for that cycle and pops/compares it once the DUT outputs settle.
module tb_mc_controller;

  typedef logic [16:0] vec_t;

  // Strobe vector layout:
  // {req, we, ifetch, ir_write, pc_write, pc_src[1:0], reg_write, wb_sel[1:0],
  //  alu_src_b[1:0], alu_op[1:0], illegal, bus_err, halted}
  localparam vec_t REQ      = 17'h10000;
  localparam vec_t WE       = 17'h08000;
  localparam vec_t IFE      = 17'h04000;
  localparam vec_t IRW      = 17'h02000;
  localparam vec_t PCW      = 17'h01000;
  localparam vec_t PCS_JAL  = 17'h00800;
  localparam vec_t PCS_BR   = 17'h00400;
  localparam vec_t REGW     = 17'h00200;
  localparam vec_t WB_PC4   = 17'h00100;
  localparam vec_t WB_MEM   = 17'h00080;
  localparam vec_t ASRC_IMM = 17'h00020;
  localparam vec_t AOP_FN   = 17'h00010;
  localparam vec_t AOP_SUB  = 17'h00008;
  localparam vec_t ILL      = 17'h00004;
  localparam vec_t BERR     = 17'h00002;
  localparam vec_t HALT     = 17'h00001;
  localparam vec_t ZERO     = 17'h00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        branch_taken = 1'b0;
  logic        ir_write, pc_write, reg_write, illegal, bus_err, halted;
  logic [1:0]  pc_src, wb_sel, alu_src_b, alu_op;
  logic [31:0] instret;
  vec_t        obs;
  vec_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  mc_controller_if bus ();

  mc_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {bus.mem_req, bus.mem_we, bus.mem_ifetch, ir_write, pc_write, pc_src,
                reg_write, wb_sel, alu_src_b, alu_op, illegal, bus_err, halted};

  initial begin
    bus.mem_ready = 1'b0;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  // Apply inputs on the falling edge and record what that cycle must show.
  task automatic drive(input logic rdy, input logic tk, input vec_t e);
    @(negedge clk);
    bus.mem_ready = rdy;
    branch_taken  = tk;
    exp_q.push_back(e);
    #1;
  endtask

  // Leaves the DUT in BOOT, just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(ZERO);
    begin
      vec_t g = exp_q.pop_front();
      vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL reset_boot obs=%05h exp=%05h", obs, g); end
    end
    vectors++;
    if (instret !== 32'd0) begin miscompares++; $display("FAIL reset_instret obs=%0d exp=0", instret); end
  endtask

  task automatic test_rtype();
    vec_t e[4];
    vec_t g;
    opcode = 7'b0110011; funct3 = 3'b000;
    e = '{REQ|IFE|IRW, ZERO, AOP_FN, REGW|PCW};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, e[i]);
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL rtype cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    @(posedge clk); #1;
    vectors++;
    if (instret !== 32'd1) begin miscompares++; $display("FAIL rtype_instret obs=%0d exp=1", instret); end
  endtask

  task automatic test_load_wait();
    vec_t e[8];
    logic [7:0] rdy;
    vec_t g;
    opcode = 7'b0000011; funct3 = 3'b010;
    e = '{REQ|IFE|IRW, ZERO, ASRC_IMM, REQ|ASRC_IMM, REQ|ASRC_IMM, REQ|ASRC_IMM,
          REQ|ASRC_IMM, REGW|WB_MEM|PCW};
    rdy = 8'b1100_0111;  // bit i = mem_ready in cycle i; DECODE/EXEC/WB ones are ignored
    for (int i = 0; i < 8; i++) begin
      drive(rdy[i], 1'b0, e[i]);
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL load cyc%0d obs=%05h exp=%05h", i, obs, g); end
      if (i == 2) opcode = 7'h7F;  // IR changes after DECODE must not matter
    end
    @(posedge clk); #1;
    vectors++;
    if (instret !== 32'd2) begin miscompares++; $display("FAIL load_instret obs=%0d exp=2", instret); end
  endtask

  task automatic test_store();
    vec_t e[4];
    vec_t g;
    opcode = 7'b0100011; funct3 = 3'b010;
    e = '{REQ|IFE|IRW, ZERO, ASRC_IMM, REQ|WE|ASRC_IMM|PCW};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, e[i]);
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL store cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    @(posedge clk); #1;
    vectors++;
    if (instret !== 32'd3) begin miscompares++; $display("FAIL store_instret obs=%0d exp=3", instret); end
  endtask

  task automatic test_branch();
    vec_t e[3];
    vec_t g;
    opcode = 7'b1100011; funct3 = 3'b000;
    for (int t = 1; t >= 0; t--) begin
      e = '{REQ|IFE|IRW, ZERO, (t == 1) ? (AOP_SUB|PCW|PCS_BR) : (AOP_SUB|PCW)};
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, (t == 1), e[i]);
        g = exp_q.pop_front(); vectors++;
        if (obs !== g) begin miscompares++; $display("FAIL beq_taken%0d cyc%0d obs=%05h exp=%05h", t, i, obs, g); end
      end
      @(posedge clk); #1;
      vectors++;
      if (instret !== 32'(5 - t)) begin miscompares++; $display("FAIL beq_taken%0d_instret obs=%0d exp=%0d", t, instret, 5 - t); end
    end
  endtask

  task automatic test_itype_jal();
    vec_t e[4];
    vec_t g;
    opcode = 7'b0010011; funct3 = 3'b000;
    e = '{REQ|IFE|IRW, ZERO, ASRC_IMM|AOP_FN, REGW|PCW};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, e[i]);
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL itype cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    opcode = 7'b1101111;
    e = '{REQ|IFE|IRW, ZERO, REGW|WB_PC4|PCW|PCS_JAL, ZERO};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, e[i]);
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL jal cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    @(posedge clk); #1;
    vectors++;
    if (instret !== 32'd7) begin miscompares++; $display("FAIL jal_instret obs=%0d exp=7", instret); end
  endtask

  task automatic test_store_reset();
    vec_t e[4];
    vec_t g;
    opcode = 7'b0100011; funct3 = 3'b010;
    e = '{REQ|IFE|IRW, ZERO, ASRC_IMM, REQ|WE|ASRC_IMM};
    for (int i = 0; i < 4; i++) begin
      drive((i == 0), 1'b0, e[i]);
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL strst cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    // Reset lands while the store is waiting in MEM.
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.push_back(REQ|WE|ASRC_IMM);
    #1;
    g = exp_q.pop_front(); vectors++;
    if (obs !== g) begin miscompares++; $display("FAIL strst_mem obs=%05h exp=%05h", obs, g); end
    @(negedge clk);
    exp_q.push_back(ZERO);
    #1;
    g = exp_q.pop_front(); vectors++;
    if (obs !== g) begin miscompares++; $display("FAIL strst_boot obs=%05h exp=%05h", obs, g); end
    vectors++;
    if (instret !== 32'd0) begin miscompares++; $display("FAIL strst_instret obs=%0d exp=0", instret); end
    reset_n = 1'b1;
  endtask

  task automatic test_illegal();
    logic [9:0] enc[4];
    vec_t g;
    enc = '{{7'b0110111, 3'b000}, {7'b0000011, 3'b011}, {7'b0100011, 3'b100}, {7'b1100011, 3'b010}};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      opcode = enc[k][9:3]; funct3 = enc[k][2:0];
      for (int i = 0; i < 6; i++) begin
        drive(1'b1, 1'b0, (i == 0) ? (REQ|IFE|IRW) : (i == 1) ? ZERO : (ILL|HALT));
        g = exp_q.pop_front(); vectors++;
        if (obs !== g) begin miscompares++; $display("FAIL illegal%0d cyc%0d obs=%05h exp=%05h", k, i, obs, g); end
      end
      vectors++;
      if (instret !== 32'd0) begin miscompares++; $display("FAIL illegal%0d_instret obs=%0d exp=0", k, instret); end
    end
  endtask

  task automatic test_timeout();
    vec_t g;
    // No answer in FETCH: four request cycles, then TRAP.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive((i == 5), 1'b0, (i < 4) ? (REQ|IFE) : (BERR|HALT));
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL tmo_fetch cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    // Answer on the last allowed cycle completes normally (R-type).
    do_reset();
    opcode = 7'b0110011; funct3 = 3'b000;
    for (int i = 0; i < 7; i++) begin
      drive((i == 3), 1'b0, (i < 3) ? (REQ|IFE) : (i == 3) ? (REQ|IFE|IRW) :
                            (i == 4) ? ZERO : (i == 5) ? AOP_FN : (REGW|PCW));
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL tmo_edge cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    // FETCH waits two cycles; MEM must get its own full budget before TRAP.
    opcode = 7'b0000011; funct3 = 3'b000;
    for (int i = 0; i < 10; i++) begin
      drive((i == 2), 1'b0, (i < 2) ? (REQ|IFE) : (i == 2) ? (REQ|IFE|IRW) :
                            (i == 3) ? ZERO : (i == 4) ? ASRC_IMM :
                            (i < 9) ? (REQ|ASRC_IMM) : (BERR|HALT));
      g = exp_q.pop_front(); vectors++;
      if (obs !== g) begin miscompares++; $display("FAIL tmo_mem cyc%0d obs=%05h exp=%05h", i, obs, g); end
    end
    vectors++;
    if (instret !== 32'd1) begin miscompares++; $display("FAIL tmo_instret obs=%0d exp=1", instret); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch();
    test_itype_jal();
    test_store_reset();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
